// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bundle: PC to IMEM/predictor, predictor answer, EX resolution, predictor update.
// Optional perf counters are present only when FETCH_PERF_CNT_EN is defined.
interface fetch_pc_ctrl_if;
    logic        id_stall;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        predict_en;
    logic [31:0] bp_new_pc;
    logic        bp_jump;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic        upd_en;
    logic [31:0] upd_addr;
    logic        upd_jumpinst;
    logic        upd_jump;
    logic        upd_predfail;
    logic [31:0] upd_target;
    logic        q_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    modport master (
        input  id_stall, bp_new_pc, bp_jump, ex_valid, ex_is_branch, ex_taken, ex_target,
        output fetch_pc, fetch_valid, predict_en, flush,
               upd_en, upd_addr, upd_jumpinst, upd_jump, upd_predfail, upd_target, q_err
`ifdef FETCH_PERF_CNT_EN
        , output perf_branch_cnt, perf_mispred_cnt
`endif
    );

    modport slave (
        output id_stall, bp_new_pc, bp_jump, ex_valid, ex_is_branch, ex_taken, ex_target,
        input  fetch_pc, fetch_valid, predict_en, flush,
               upd_en, upd_addr, upd_jumpinst, upd_jump, upd_predfail, upd_target, q_err
`ifdef FETCH_PERF_CNT_EN
        , input perf_branch_cnt, perf_mispred_cnt
`endif
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC generator with in-flight prediction queue; predictor update is 1 cycle after EX pop,
// redirect/flush on mispredict; fetch stalls on id_stall or full queue. Option: FETCH_PERF_CNT_EN.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_ctrl_if.master bus
);
    localparam logic [PTR_W:0]   L_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);

    // The predicted direction is implied by pred_next, so only pc and pred_next are kept.
    logic [31:0]      r_q_pc   [DEPTH];
    logic [31:0]      r_q_next [DEPTH];

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_flush;
    logic             r_upd_en;
    logic [31:0]      r_upd_addr;
    logic             r_upd_jumpinst;
    logic             r_upd_jump;
    logic             r_upd_predfail;
    logic [31:0]      r_upd_target;
    logic             r_q_err;

    logic             w_pop;
    logic             w_fetch_valid;
    logic             w_fire;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_next;
    logic [31:0]      w_actual_next;
    logic             w_mispred;

    assign w_pop         = bus.ex_valid & (r_count != '0);
    assign w_fetch_valid = ~reset & ~r_flush & ((r_count != L_FULL) | w_pop);
    assign w_fire        = w_fetch_valid & ~bus.id_stall;
    assign w_head_pc     = r_q_pc[r_head];
    assign w_head_next   = r_q_next[r_head];
    assign w_actual_next = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target : w_head_pc + 32'd4;
    assign w_mispred     = w_pop & (w_actual_next != w_head_next);

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_q_pc[r_tail]   <= r_pc;
            r_q_next[r_tail] <= bus.bp_new_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_mispred;
            if (w_mispred) begin
                // Redirect wins over any same-cycle push; everything in flight is wrong-path.
                r_pc    <= w_actual_next;
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_fire) begin
                    r_pc   <= bus.bp_new_pc;
                    r_tail <= r_tail + L_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + L_PTR_ONE;
                end
                if (w_fire && !w_pop) begin
                    r_count <= r_count + L_CNT_ONE;
                end else if (!w_fire && w_pop) begin
                    r_count <= r_count - L_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upd_en       <= 1'b0;
            r_upd_addr     <= '0;
            r_upd_jumpinst <= 1'b0;
            r_upd_jump     <= 1'b0;
            r_upd_predfail <= 1'b0;
            r_upd_target   <= '0;
            r_q_err        <= 1'b0;
        end else begin
            r_upd_en       <= w_pop;
            r_upd_addr     <= w_pop ? w_head_pc : '0;
            r_upd_jumpinst <= w_pop & bus.ex_is_branch;
            r_upd_jump     <= w_pop & bus.ex_is_branch & bus.ex_taken;
            r_upd_predfail <= w_mispred;
            r_upd_target   <= w_pop ? bus.ex_target : '0;
            r_q_err        <= r_q_err | (bus.ex_valid & (r_count == '0));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_branch_cnt;
    logic [31:0] r_perf_mispred_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_branch_cnt  <= '0;
            r_perf_mispred_cnt <= '0;
        end else begin
            if (w_pop & bus.ex_is_branch) r_perf_branch_cnt  <= r_perf_branch_cnt + 32'd1;
            if (w_mispred)                r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
        end
    end

    assign bus.perf_branch_cnt  = r_perf_branch_cnt;
    assign bus.perf_mispred_cnt = r_perf_mispred_cnt;
`endif

    assign bus.fetch_pc     = r_pc;
    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.predict_en   = w_fire;
    assign bus.flush        = r_flush;
    assign bus.upd_en       = r_upd_en;
    assign bus.upd_addr     = r_upd_addr;
    assign bus.upd_jumpinst = r_upd_jumpinst;
    assign bus.upd_jump     = r_upd_jump;
    assign bus.upd_predfail = r_upd_predfail;
    assign bus.upd_target   = r_upd_target;
    assign bus.q_err        = r_q_err;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, hand sequences for reset/q_err, random vs queue model.
module tb_fetch_pc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(4), .PTR_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] bpn, input logic bpj,
                         input logic exv, input logic exb, input logic ext, input logic [31:0] tgt);
        bus.id_stall     = st;
        bus.bp_new_pc    = bpn;
        bus.bp_jump      = bpj;
        bus.ex_valid     = exv;
        bus.ex_is_branch = exb;
        bus.ex_taken     = ext;
        bus.ex_target    = tgt;
    endtask

    // in_f = {stall, bp_jump, ex_valid, ex_is_branch, ex_taken}
    // ex_f = {fetch_valid, predict_en, flush, upd_en, upd_jumpinst, upd_jump, upd_predfail}
    typedef struct {
        logic [4:0]  in_f;
        logic [31:0] bpn;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [6:0]  ex_f;
        logic [31:0] e_ua;
        logic [31:0] e_ut;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] nxt;
    } ent_t;

    vec_t tbl [23];

    ent_t        m_q [$];
    ent_t        h;
    logic [31:0] m_pc, m_ua, m_ut, act;
    logic        m_flush, m_qerr, m_ue, m_uji, m_uj, m_upf;
    logic        st, bpj, exv, exb, ext, fv, pop, fire, mis;
    logic [31:0] bpn, tgt;
    logic [31:0] m_br, m_mp;

    initial begin
        tbl[0]  = '{5'b00000, 32'h04,  32'h000, 32'h000, 7'b1100000, 32'h00, 32'h000};
        tbl[1]  = '{5'b00100, 32'h08,  32'h000, 32'h004, 7'b1100000, 32'h00, 32'h000};
        tbl[2]  = '{5'b00100, 32'h0C,  32'h000, 32'h008, 7'b1101000, 32'h00, 32'h000};
        tbl[3]  = '{5'b00000, 32'h10,  32'h000, 32'h00C, 7'b1101000, 32'h04, 32'h000};
        tbl[4]  = '{5'b00000, 32'h14,  32'h000, 32'h010, 7'b1100000, 32'h00, 32'h000};
        tbl[5]  = '{5'b00100, 32'h18,  32'h000, 32'h014, 7'b1100000, 32'h00, 32'h000};
        tbl[6]  = '{5'b00100, 32'h1C,  32'h000, 32'h018, 7'b1101000, 32'h08, 32'h000};
        tbl[7]  = '{5'b00111, 32'h20,  32'h040, 32'h01C, 7'b1101000, 32'h0C, 32'h000};
        tbl[8]  = '{5'b00000, 32'h44,  32'h000, 32'h040, 7'b0011111, 32'h10, 32'h040};
        tbl[9]  = '{5'b01000, 32'h80,  32'h000, 32'h040, 7'b1100000, 32'h00, 32'h000};
        tbl[10] = '{5'b00111, 32'h84,  32'h080, 32'h080, 7'b1100000, 32'h00, 32'h000};
        tbl[11] = '{5'b00000, 32'h88,  32'h000, 32'h084, 7'b1101110, 32'h40, 32'h080};
        tbl[12] = '{5'b00000, 32'h8C,  32'h000, 32'h088, 7'b1100000, 32'h00, 32'h000};
        tbl[13] = '{5'b00000, 32'h90,  32'h000, 32'h08C, 7'b1100000, 32'h00, 32'h000};
        tbl[14] = '{5'b00000, 32'h94,  32'h000, 32'h090, 7'b0000000, 32'h00, 32'h000};
        tbl[15] = '{5'b00000, 32'h94,  32'h000, 32'h090, 7'b0000000, 32'h00, 32'h000};
        tbl[16] = '{5'b00100, 32'h94,  32'h000, 32'h090, 7'b1100000, 32'h00, 32'h000};
        tbl[17] = '{5'b00000, 32'h98,  32'h000, 32'h094, 7'b0001000, 32'h80, 32'h000};
        tbl[18] = '{5'b10100, 32'h98,  32'h000, 32'h094, 7'b1000000, 32'h00, 32'h000};
        tbl[19] = '{5'b00000, 32'h98,  32'h000, 32'h094, 7'b1101000, 32'h84, 32'h000};
        tbl[20] = '{5'b10111, 32'h9C,  32'h200, 32'h098, 7'b1000000, 32'h00, 32'h000};
        tbl[21] = '{5'b00000, 32'h204, 32'h000, 32'h200, 7'b0011111, 32'h88, 32'h200};
        tbl[22] = '{5'b00000, 32'h204, 32'h000, 32'h200, 7'b1100000, 32'h00, 32'h000};

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk ("rst_pc",     bus.fetch_pc, 32'h0);
        chk1("rst_fv",     bus.fetch_valid, 1'b0);
        chk1("rst_flush",  bus.flush, 1'b0);
        chk1("rst_upd_en", bus.upd_en, 1'b0);
        chk1("rst_q_err",  bus.q_err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].in_f[4], tbl[i].bpn, tbl[i].in_f[3], tbl[i].in_f[2],
                  tbl[i].in_f[1], tbl[i].in_f[0], tbl[i].tgt);
            #1;
            chk ($sformatf("r%0d_pc", i),       bus.fetch_pc,     tbl[i].e_pc);
            chk1($sformatf("r%0d_fv", i),       bus.fetch_valid,  tbl[i].ex_f[6]);
            chk1($sformatf("r%0d_pe", i),       bus.predict_en,   tbl[i].ex_f[5]);
            chk1($sformatf("r%0d_flush", i),    bus.flush,        tbl[i].ex_f[4]);
            chk1($sformatf("r%0d_upd_en", i),   bus.upd_en,       tbl[i].ex_f[3]);
            chk1($sformatf("r%0d_upd_ji", i),   bus.upd_jumpinst, tbl[i].ex_f[2]);
            chk1($sformatf("r%0d_upd_j", i),    bus.upd_jump,     tbl[i].ex_f[1]);
            chk1($sformatf("r%0d_upd_pf", i),   bus.upd_predfail, tbl[i].ex_f[0]);
            chk ($sformatf("r%0d_upd_addr", i), bus.upd_addr,     tbl[i].e_ua);
            chk ($sformatf("r%0d_upd_tgt", i),  bus.upd_target,   tbl[i].e_ut);
            chk1($sformatf("r%0d_q_err", i),    bus.q_err,        1'b0);
        end

        // Mispredict while stalled, then reset while flush/upd are live.
        @(negedge clk);
        drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk ("stall_redir_pc",  bus.fetch_pc, 32'h300);
        chk1("stall_redir_fl",  bus.flush, 1'b1);
        chk ("stall_redir_ua",  bus.upd_addr, 32'h200);
        chk1("stall_redir_pf",  bus.upd_predfail, 1'b1);
        reset = 1'b1;
        #1;
        chk ("midrst_pc",     bus.fetch_pc, 32'h0);
        chk1("midrst_flush",  bus.flush, 1'b0);
        chk1("midrst_upd_en", bus.upd_en, 1'b0);
        chk1("midrst_fv",     bus.fetch_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk1("post_rst_fv", bus.fetch_valid, 1'b1);
        chk ("post_rst_pc", bus.fetch_pc, 32'h0);

        // EX resolves with nothing in flight.
        drive(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        #1;
        chk1("qerr_before", bus.q_err, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk1("qerr_set",    bus.q_err, 1'b1);
        chk1("qerr_upd_en", bus.upd_en, 1'b0);
        chk ("qerr_pc",     bus.fetch_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk ("qerr_perf_br", bus.perf_branch_cnt, 32'h0);
        chk ("qerr_perf_mp", bus.perf_mispred_cnt, 32'h0);
`endif
        @(negedge clk);
        #1;
        chk1("qerr_sticky", bus.q_err, 1'b1);

        // Random traffic against a queue-level model.
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_q.delete();
        m_pc = 32'h0; m_flush = 1'b0; m_qerr = 1'b0;
        m_ue = 1'b0; m_uji = 1'b0; m_uj = 1'b0; m_upf = 1'b0; m_ua = 32'h0; m_ut = 32'h0;
        m_br = 32'h0; m_mp = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            st  = ($urandom_range(0, 3) == 0);
            bpj = ($urandom_range(0, 2) == 0);
            bpn = bpj ? ($urandom & 32'h0000_03FC) : m_pc + 32'd4;
            exv = ($urandom_range(0, 9) < 4);
            exb = ($urandom_range(0, 1) == 1);
            ext = ($urandom_range(0, 1) == 1);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1) tgt = m_q[0].nxt;
            else tgt = $urandom & 32'h0000_03FC;
            drive(st, bpn, bpj, exv, exb, ext, tgt);

            pop  = exv && (m_q.size() > 0);
            fv   = !m_flush && ((m_q.size() < 4) || pop);
            fire = fv && !st;
            #1;
            chk ("rnd_pc",       bus.fetch_pc,     m_pc);
            chk1("rnd_fv",       bus.fetch_valid,  fv);
            chk1("rnd_pe",       bus.predict_en,   fire);
            chk1("rnd_flush",    bus.flush,        m_flush);
            chk1("rnd_upd_en",   bus.upd_en,       m_ue);
            chk ("rnd_upd_addr", bus.upd_addr,     m_ua);
            chk1("rnd_upd_ji",   bus.upd_jumpinst, m_uji);
            chk1("rnd_upd_j",    bus.upd_jump,     m_uj);
            chk1("rnd_upd_pf",   bus.upd_predfail, m_upf);
            chk ("rnd_upd_tgt",  bus.upd_target,   m_ut);
            chk1("rnd_q_err",    bus.q_err,        m_qerr);
`ifdef FETCH_PERF_CNT_EN
            chk ("rnd_perf_br",  bus.perf_branch_cnt,  m_br);
            chk ("rnd_perf_mp",  bus.perf_mispred_cnt, m_mp);
`endif
            mis = 1'b0;
            m_ue = 1'b0; m_uji = 1'b0; m_uj = 1'b0; m_upf = 1'b0; m_ua = 32'h0; m_ut = 32'h0;
            if (pop) begin
                h   = m_q.pop_front();
                act = (exb && ext) ? tgt : h.pc + 32'd4;
                mis = (act != h.nxt);
                m_ue = 1'b1; m_ua = h.pc; m_uji = exb; m_uj = exb && ext; m_upf = mis; m_ut = tgt;
                if (exb) m_br = m_br + 32'd1;
                if (mis) m_mp = m_mp + 32'd1;
            end else if (exv) begin
                m_qerr = 1'b1;
            end
            if (mis) begin
                m_q.delete();
                m_pc = act;
            end else if (fire) begin
                m_q.push_back('{m_pc, bpn});
                m_pc = bpn;
            end
            m_flush = mis;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
